adpcm_code_packer: RTL and testbench
====================================

// Module: adpcm_code_packer
// PURPOSE
// - Downstream of the ADPCM encoder: collects one 4-bit code per valid cycle into 16-bit words.
// - Buffers completed words in a small FIFO and drains them over a valid/ready stream
//   to the storage/transport side.
// - Provides a flush for end-of-stream partial words and a sticky overflow flag.
// PARAMETERS
// - FIFO_DEPTH  default 8  number of 16-bit words buffered; power of two, >= 2.
// - PAD_NIBBLE  default 0  4-bit value used to fill unused nibbles on flush.
// PORTS
// - clk         in   1   clock; all logic on rising edge.
// - reset       in   1   asynchronous, active-low reset (0 = reset asserted).
// - code_valid  in   1   code is valid this cycle; no backpressure on this side.
// - code        in   4   ADPCM code from the encoder.
// - flush       in   1   one-cycle pulse: close the current partial word.
// - word_valid  out  1   FIFO head is valid.
// - word_data   out  16  FIFO head word.
// - word_ready  in   1   consumer accepts the head when word_valid && word_ready.
// - fill_level  out  $clog2(FIFO_DEPTH)+1   number of words held in the FIFO.
// - overflow    out  1   sticky; set when a completed word is dropped.
// BEHAVIOUR
// - Reset values: word_valid=0, word_data=0, fill_level=0, overflow=0. Nibble index=0,
//   assembly register=0, FIFO pointers=0. Reset mid-word or mid-drain discards all state.
// - Packing order: the 1st code of a word goes in [3:0], the 2nd in [7:4], the 3rd in [11:8],
//   the 4th in [15:12].
// - Assembler: 2-bit nibble index.
//   - On an edge where code_valid=1, the code is written at the current index and the index
//     increments.
//   - When index==3 and code_valid=1, the word completes: push to the FIFO, index wraps to 0.
// - Flush: on an edge where flush=1 and index!=0 (after including any same-cycle code),
//   unused nibbles are filled with PAD_NIBBLE, the word is pushed, and the index goes to 0.
//   - flush with index==0 and no same-cycle code: no-op.
//   - flush on the same edge as the 4th code: exactly one word is pushed; no empty word.
// - Latency: a word completed at edge k is visible on word_valid/word_data after edge k
//   (1 cycle). FIFO output is registered, first-word-fall-through.
// - Pop: on an edge where word_valid && word_ready. word_data is stable while word_valid=1
//   and word_ready=0.
// - Full: a push with fill_level==FIFO_DEPTH and no same-edge pop drops the new word.
//   - overflow is set and FIFO contents are unchanged.
//   - Push and pop on the same edge when full: both occur; no overflow.
// - Empty: a push and pop on the same edge are impossible (word_valid=0); the push lands
//   normally.
// - Pointers wrap modulo FIFO_DEPTH. fill_level is updated on the same edge as the push/pop.
// - overflow clears only on reset.
// CONFIGURATION
// - Macro ADPCM_PACK_CNT_EN.
//   - Defined: adds output word_cnt (out, 16) = count of popped words since reset, wrapping
//     0xFFFF->0x0000. Reset value 0.
//   - Undefined: the port and counter do not exist. All other behaviour is identical.
// TESTING
// - Codes 1,2,3,4 on 4 consecutive cycles, word_ready=1 -> one word 0x4321, word_valid high
//   for 1 cycle after the 4th edge.
// - Codes A,B,C, then flush pulse -> word 0x0CBA. A second flush with index==0 -> no word
//   pushed.
// - word_ready=0, 36 codes -> fill_level=8, the 9th word is dropped, overflow=1. Draining
//   yields the first 8 words in order.
// - FIFO full, 4th code arrives with word_ready=1 on the same edge -> pop and push both occur;
//   fill_level stays 8 and overflow stays 0.
// - 2 codes in, reset pulled low mid-word, then codes 5,6,7,8 -> word 0x8765. No stale
//   nibbles; fill_level was 0 after reset.
// - With ADPCM_PACK_CNT_EN: 3 popped words -> word_cnt=3. Preload 0xFFFF and pop 1 word ->
//   word_cnt=0.

Source files
------------

// File: rtl/adpcm_code_packer_if.sv
// Word stream between the ADPCM code packer and the storage/transport side.
// The packer drives the master modport; the consumer uses the slave modport.
interface adpcm_code_packer_if;
  logic        word_valid;
  logic [15:0] word_data;
  logic        word_ready;

  modport master (
    output word_valid,
    output word_data,
    input  word_ready
  );

  modport slave (
    input  word_valid,
    input  word_data,
    output word_ready
  );
endinterface

// File: rtl/adpcm_code_packer.sv
// Packs 4-bit ADPCM codes into 16-bit words and buffers them in a FWFT FIFO.
// Define ADPCM_PACK_CNT_EN to add the word_cnt popped-word counter output.
module adpcm_code_packer #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] PAD_NIBBLE = 4'h0
) (
  input  logic clk,
  input  logic reset,
  input  logic code_valid,
  input  logic [3:0] code,
  input  logic flush,
  adpcm_code_packer_if.master word,
  output logic [$clog2(FIFO_DEPTH):0] fill_level,
`ifdef ADPCM_PACK_CNT_EN
  output logic [15:0] word_cnt,
`endif
  output logic overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [1:0]  idx;
  logic [15:0] asm_q;
  logic [15:0] mem [FIFO_DEPTH];
  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  cnt_t        count;
  logic        valid_q;
  logic [15:0] data_q;

  logic [15:0] asm_in;
  logic [15:0] padded;
  logic [15:0] push_word;
  logic [15:0] head_n;
  logic [1:0]  idx_n;
  logic        complete;
  logic        flush_word;
  logic        push;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic        drop;
  ptr_t        rd_n;
  cnt_t        count_n;

  assign word.word_valid = valid_q;
  assign word.word_data  = data_q;
  assign fill_level      = count;

  always_comb begin
    asm_in = asm_q;
    if (code_valid)
      asm_in[{idx, 2'b00} +: 4] = code;
    idx_n    = idx + {1'b0, code_valid};
    complete = code_valid && (idx == 2'd3);

    // Nibbles at or above the post-code index were never written.
    padded = asm_in;
    for (int i = 0; i < 4; i++)
      if (2'(i) >= idx_n)
        padded[i*4 +: 4] = PAD_NIBBLE;

    flush_word = flush && (idx_n != 2'd0);
    push       = complete || flush_word;
    push_word  = complete ? asm_in : padded;

    pop     = valid_q && word.word_ready;
    full    = (count == cnt_t'(FIFO_DEPTH));
    push_ok = push && (!full || pop);
    drop    = push && full && !pop;
    rd_n    = rd_ptr + ptr_t'(pop);
    count_n = count + cnt_t'(push_ok) - cnt_t'(pop);

    // A push into the slot the head is moving to bypasses the array.
    if (push_ok && (rd_n == wr_ptr))
      head_n = push_word;
    else
      head_n = mem[rd_n];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx      <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      idx     <= push ? 2'd0 : idx_n;
      asm_q   <= push ? 16'h0 : asm_in;
      if (push_ok)
        mem[wr_ptr] <= push_word;
      wr_ptr  <= wr_ptr + ptr_t'(push_ok);
      rd_ptr  <= rd_n;
      count   <= count_n;
      valid_q <= (count_n != '0);
      data_q  <= head_n;
      if (drop)
        overflow <= 1'b1;
    end
  end

`ifdef ADPCM_PACK_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      word_cnt <= '0;
    else if (pop)
      word_cnt <= word_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adpcm_code_packer.sv
// Scoreboard bench for adpcm_code_packer: directed codes in, expected words
// queued, an independent monitor pops and compares on every handshake.
module tb_adpcm_code_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic [3:0] code = 4'h0;
  logic       flush = 1'b0;
  logic [3:0] fill_level;
  logic       overflow;
`ifdef ADPCM_PACK_CNT_EN
  logic [15:0] word_cnt;
`endif

  adpcm_code_packer_if bus();

  adpcm_code_packer #(.FIFO_DEPTH(8), .PAD_NIBBLE(4'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code       (code),
    .flush      (flush),
    .word       (bus),
    .fill_level (fill_level),
`ifdef ADPCM_PACK_CNT_EN
    .word_cnt   (word_cnt),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] expq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got 0x%0h expected none",
                   bus.word_data);
        end else begin
          logic [15:0] e;
          e = expq.pop_front();
          if (bus.word_data !== e) begin
            errors++;
            $display("FAIL word_data: got 0x%0h expected 0x%0h",
                     bus.word_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [3:0] c, input logic fl);
    code_valid = 1'b1;
    code = c;
    flush = fl;
    tick();
    code_valid = 1'b0;
    flush = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic drain(input string nm);
    int n;
    bus.word_ready = 1'b1;
    n = 0;
    while (bus.word_valid === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, "_drain_done"}, {31'd0, bus.word_valid}, 32'd0);
    chk({nm, "_queue_empty"}, expq.size(), 32'd0);
  endtask

  function automatic logic [3:0] wcode(input int j, input int n);
    return 4'((j * 5 + n * 3) & 15);
  endfunction

  initial begin
    bus.word_ready = 1'b0;

    // Values held during reset.
    tick();
    chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_data", {16'd0, bus.word_data}, 32'd0);
    chk("rst_fill", {28'd0, fill_level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    tick();

    // Four codes form 0x4321.
    bus.word_ready = 1'b1;
    expq.push_back(16'h4321);
    put(4'h1, 1'b0);
    put(4'h2, 1'b0);
    put(4'h3, 1'b0);
    chk("t1_not_yet", {31'd0, bus.word_valid}, 32'd0);
    put(4'h4, 1'b0);
    chk("t1_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("t1_data", {16'd0, bus.word_data}, 32'h4321);
    chk("t1_fill", {28'd0, fill_level}, 32'd1);
    tick();
    chk("t1_one_cycle", {31'd0, bus.word_valid}, 32'd0);

    // Partial word closed by flush, then a no-op flush.
    expq.push_back(16'h0CBA);
    put(4'hA, 1'b0);
    put(4'hB, 1'b0);
    put(4'hC, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_flush_word", {16'd0, bus.word_data}, 32'h0CBA);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t2_empty_flush", {28'd0, fill_level}, 32'd0);
    tick();
    chk("t2_no_word", {31'd0, bus.word_valid}, 32'd0);

    // Flush on the same edge as the 4th code yields one word.
    expq.push_back(16'h8765);
    put(4'h5, 1'b0);
    put(4'h6, 1'b0);
    put(4'h7, 1'b0);
    put(4'h8, 1'b1);
    chk("t2b_fill", {28'd0, fill_level}, 32'd1);
    tick();
    tick();
    chk("t2b_single", {31'd0, bus.word_valid}, 32'd0);
    drain("t2");
`ifdef ADPCM_PACK_CNT_EN
    chk("cnt_three", {16'd0, word_cnt}, 32'd3);
`endif

    // Full FIFO: push and pop on the same edge.
    do_reset();
    bus.word_ready = 1'b0;
    for (int j = 0; j < 8; j++) begin
      expq.push_back({wcode(j, 3), wcode(j, 2), wcode(j, 1), wcode(j, 0)});
      for (int n = 0; n < 4; n++)
        put(wcode(j, n), 1'b0);
    end
    chk("t4_full", {28'd0, fill_level}, 32'd8);
    expq.push_back({wcode(8, 3), wcode(8, 2), wcode(8, 1), wcode(8, 0)});
    for (int n = 0; n < 3; n++)
      put(wcode(8, n), 1'b0);
    code_valid = 1'b1;
    code = wcode(8, 3);
    bus.word_ready = 1'b1;
    tick();
    code_valid = 1'b0;
    bus.word_ready = 1'b0;
    chk("t4_fill_stays", {28'd0, fill_level}, 32'd8);
    chk("t4_no_ovf", {31'd0, overflow}, 32'd0);
    drain("t4");

    // Overflow: 36 codes with no consumer.
    do_reset();
    bus.word_ready = 1'b0;
    for (int j = 0; j < 9; j++) begin
      if (j < 8)
        expq.push_back({wcode(j, 3), wcode(j, 2), wcode(j, 1), wcode(j, 0)});
      for (int n = 0; n < 4; n++)
        put(wcode(j, n), 1'b0);
      if (j == 7) begin
        chk("t3_fill8", {28'd0, fill_level}, 32'd8);
        chk("t3_ovf_pre", {31'd0, overflow}, 32'd0);
      end
    end
    chk("t3_fill_after", {28'd0, fill_level}, 32'd8);
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    chk("t3_head_stable", {16'd0, bus.word_data},
        {16'd0, wcode(0, 3), wcode(0, 2), wcode(0, 1), wcode(0, 0)});
    drain("t3");
    chk("t3_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Reset mid-word discards stale nibbles.
    bus.word_ready = 1'b1;
    put(4'hE, 1'b0);
    put(4'hF, 1'b0);
    reset = 1'b0;
    tick();
    chk("t5_fill_rst", {28'd0, fill_level}, 32'd0);
    chk("t5_ovf_rst", {31'd0, overflow}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    expq.push_back(16'h8765);
    put(4'h5, 1'b0);
    put(4'h6, 1'b0);
    put(4'h7, 1'b0);
    put(4'h8, 1'b0);
    chk("t5_data", {16'd0, bus.word_data}, 32'h8765);
    drain("t5");
`ifdef ADPCM_PACK_CNT_EN
    chk("cnt_after_rst", {16'd0, word_cnt}, 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
